// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted request over a req/gnt/rvalid bus.
// Loads return lane-aligned, sign/zero-extended data; ready stays low while busy.
module lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_valid_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_unsigned_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [4:0]  lsu_rd_i,
    output logic        lsu_ready_o,
    output logic        lsu_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic [4:0]  lsu_rd_o,
    output logic        lsu_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [2:0] {
        s_idle  = 3'd0,
        s_req   = 3'd1,
        s_wait  = 3'd2,
        s_done  = 3'd3,
        s_misal = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Captured request attributes
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;

    // Registered outputs
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        req_q, req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;

    logic        accept;
    logic        misal;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // ready_q mirrors (state_q == s_idle), so accept is decided in IDLE only
    assign accept = lsu_valid_i & ready_q;

    always_comb begin
        misal = 1'b0;
        unique case (lsu_size_i)
            SizeByte: misal = 1'b0;
            SizeHalf: misal = lsu_addr_i[0];
            SizeWord: misal = |lsu_addr_i[1:0];
            default:  misal = 1'b1;
        endcase
    end

    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = lsu_wdata_i;
        unique case (lsu_size_i)
            SizeByte: begin
                be_calc    = 4'b0001 << lsu_addr_i[1:0];
                wdata_calc = {4{lsu_wdata_i[7:0]}};
            end
            SizeHalf: begin
                be_calc    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_calc = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = lsu_wdata_i;
            end
        endcase
    end

    always_comb begin
        shifted  = mem_rdata_i >> {addr_lo_q, 3'b000};
        load_ext = shifted;
        unique case (size_q)
            SizeByte: load_ext = {{24{shifted[7] & ~uns_q}}, shifted[7:0]};
            SizeHalf: load_ext = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
            default:  load_ext = shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= s_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            s_idle: begin
                if (accept) begin
                    state_d = misal ? s_misal : s_req;
                end
            end
            s_req: begin
                if (mem_gnt_i) begin
                    state_d = s_wait;
                end
            end
            s_wait: begin
                if (mem_rvalid_i) begin
                    state_d = s_done;
                end
            end
            s_done:  state_d = s_idle;
            s_misal: state_d = s_idle;
            default: state_d = s_idle;
        endcase
    end

    // Output/datapath next values; every output is a register driven from state_d
    always_comb begin
        addr_lo_d  = addr_lo_q;
        size_d     = size_q;
        uns_d      = uns_q;
        we_d       = we_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        rd_out_d   = rd_out_q;
        mem_we_d   = mem_we_q;
        be_d       = be_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;

        ready_d    = (state_d == s_idle);
        done_d     = (state_d == s_done);
        misalign_d = (state_d == s_misal);
        req_d      = (state_d == s_req);

        if (state_q == s_idle && accept) begin
            addr_lo_d = lsu_addr_i[1:0];
            size_d    = lsu_size_i;
            uns_d     = lsu_unsigned_i;
            we_d      = lsu_we_i;
            rd_d      = lsu_rd_i;
            if (!misal) begin
                mem_we_d = lsu_we_i;
                be_d     = be_calc;
                maddr_d  = {lsu_addr_i[31:2], 2'b00};
                mwdata_d = wdata_calc;
            end
        end

        if (state_q == s_wait && mem_rvalid_i) begin
            rdata_d  = we_q ? 32'h0 : load_ext;
            rd_out_d = we_q ? 5'd0 : rd_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_lo_q  <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= 5'd0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= 32'h0;
            rd_out_q   <= 5'd0;
            req_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            be_q       <= 4'b0000;
            maddr_q    <= 32'h0;
            mwdata_q   <= 32'h0;
        end else begin
            addr_lo_q  <= addr_lo_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            rdata_q    <= rdata_d;
            rd_out_q   <= rd_out_d;
            req_q      <= req_d;
            mem_we_q   <= mem_we_d;
            be_q       <= be_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
        end
    end

    assign lsu_ready_o    = ready_q;
    assign lsu_done_o     = done_q;
    assign lsu_misalign_o = misalign_q;
    assign lsu_rdata_o    = rdata_q;
    assign lsu_rd_o       = rd_out_q;
    assign mem_req_o      = req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_be_o       = be_q;
    assign mem_addr_o     = maddr_q;
    assign mem_wdata_o    = mwdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads/stores of each size, grant/response stalls, misaligned
// rejects, spurious rvalid and reset in the middle of a transaction.
module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_valid_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [4:0]  lsu_rd_i;
    logic        lsu_ready_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic [4:0]  lsu_rd_o;
    logic        lsu_misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int total = 0;
    int bad   = 0;

    lsu dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_rd_i       (lsu_rd_i),
        .lsu_ready_o    (lsu_ready_o),
        .lsu_done_o     (lsu_done_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_rd_o       (lsu_rd_o),
        .lsu_misalign_o (lsu_misalign_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"},    {31'd0, lsu_ready_o}, 32'd1);
        check({tag, ".done"},     {31'd0, lsu_done_o}, 32'd0);
        check({tag, ".misalign"}, {31'd0, lsu_misalign_o}, 32'd0);
        check({tag, ".rdata"},    lsu_rdata_o, 32'h0);
        check({tag, ".rd"},       {27'd0, lsu_rd_o}, 32'd0);
        check({tag, ".req"},      {31'd0, mem_req_o}, 32'd0);
        check({tag, ".we"},       {31'd0, mem_we_o}, 32'd0);
        check({tag, ".be"},       {28'd0, mem_be_o}, 32'd0);
        check({tag, ".addr"},     mem_addr_o, 32'h0);
        check({tag, ".wdata"},    mem_wdata_o, 32'h0);
    endtask

    task automatic xfer(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int gnt_wait, input int rv_wait,
                        input logic [31:0] bus_rdata, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic [4:0] exp_rd);
        check({tag, ".ready_in"}, {31'd0, lsu_ready_o}, 32'd1);
        lsu_valid_i    = 1'b1;
        lsu_we_i       = we;
        lsu_size_i     = size;
        lsu_unsigned_i = uns;
        lsu_addr_i     = addr;
        lsu_wdata_i    = wdata;
        lsu_rd_i       = rd;
        tick();
        lsu_valid_i = 1'b0;
        lsu_wdata_i = 32'hDEAD_0000;
        lsu_addr_i  = 32'hFFFF_FFFF;
        for (int g = 0; g <= gnt_wait; g++) begin
            check({tag, ".req"},   {31'd0, mem_req_o}, 32'd1);
            check({tag, ".we"},    {31'd0, mem_we_o}, {31'd0, we});
            check({tag, ".be"},    {28'd0, mem_be_o}, {28'd0, exp_be});
            check({tag, ".addr"},  mem_addr_o, exp_addr);
            check({tag, ".wdata"}, mem_wdata_o, exp_wdata);
            check({tag, ".busy"},  {31'd0, lsu_ready_o}, 32'd0);
            mem_gnt_i = (g == gnt_wait);
            tick();
        end
        mem_gnt_i = 1'b0;
        for (int r = 0; r <= rv_wait; r++) begin
            check({tag, ".req_drop"}, {31'd0, mem_req_o}, 32'd0);
            check({tag, ".early"},    {31'd0, lsu_done_o}, 32'd0);
            check({tag, ".wbusy"},    {31'd0, lsu_ready_o}, 32'd0);
            if (r == rv_wait) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = bus_rdata;
            end
            tick();
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0BAD_F00D;
        check({tag, ".done"},     {31'd0, lsu_done_o}, 32'd1);
        check({tag, ".rdata"},    lsu_rdata_o, exp_rdata);
        check({tag, ".rd"},       {27'd0, lsu_rd_o}, {27'd0, exp_rd});
        check({tag, ".dready"},   {31'd0, lsu_ready_o}, 32'd0);
        tick();
        check({tag, ".done_end"}, {31'd0, lsu_done_o}, 32'd0);
        check({tag, ".ready_end"}, {31'd0, lsu_ready_o}, 32'd1);
    endtask

    task automatic misal_req(input string tag, input logic [1:0] size, input logic [31:0] addr);
        lsu_valid_i = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_size_i  = size;
        lsu_addr_i  = addr;
        lsu_rd_i    = 5'd3;
        tick();
        lsu_valid_i = 1'b0;
        check({tag, ".pulse"}, {31'd0, lsu_misalign_o}, 32'd1);
        check({tag, ".req"},   {31'd0, mem_req_o}, 32'd0);
        check({tag, ".ready"}, {31'd0, lsu_ready_o}, 32'd0);
        check({tag, ".done"},  {31'd0, lsu_done_o}, 32'd0);
        tick();
        check({tag, ".pulse_end"}, {31'd0, lsu_misalign_o}, 32'd0);
        check({tag, ".req2"},      {31'd0, mem_req_o}, 32'd0);
        check({tag, ".ready2"},    {31'd0, lsu_ready_o}, 32'd1);
    endtask

    initial begin
        rst_i          = 1'b1;
        lsu_valid_i    = 1'b0;
        lsu_we_i       = 1'b0;
        lsu_size_i     = 2'b00;
        lsu_unsigned_i = 1'b0;
        lsu_addr_i     = 32'h0;
        lsu_wdata_i    = 32'h0;
        lsu_rd_i       = 5'd0;
        mem_gnt_i      = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = 32'h0;
        tick();
        tick();
        check_reset_vals("rst");
        rst_i = 1'b0;
        tick();
        check_reset_vals("post_rst");

        xfer("lb", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd5, 0, 0, 32'h80FF_1234,
             32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80, 5'd5);
        xfer("lhu", 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 5'd6, 0, 0, 32'h8001_0000,
             32'h0000_0200, 4'b1100, 32'h0, 32'h0000_8001, 5'd6);
        xfer("sh", 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 5'd9, 0, 0, 32'h5555_5555,
             32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0, 5'd0);
        xfer("sb", 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00EE, 5'd4, 0, 0, 32'h1111_1111,
             32'h0000_0100, 4'b0010, 32'hEEEE_EEEE, 32'h0, 5'd0);
        xfer("sw", 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h0123_4567, 5'd2, 1, 0, 32'h0,
             32'h0000_0008, 4'b1111, 32'h0123_4567, 32'h0, 5'd0);
        xfer("lbu", 1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0, 5'd11, 0, 0, 32'h0000_9A00,
             32'h0000_0040, 4'b0010, 32'h0, 32'h0000_009A, 5'd11);
        // Grant withheld 3 cycles, rvalid 2 cycles after grant
        xfer("lh_stall", 1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0, 5'd12, 3, 1, 32'hC3A5_0000,
             32'h0000_0004, 4'b1100, 32'h0, 32'hFFFF_C3A5, 5'd12);

        misal_req("mis_w", 2'b10, 32'h0000_0101);
        misal_req("mis_sz3", 2'b11, 32'h0000_0100);
        misal_req("mis_h", 2'b01, 32'h0000_0201);

        // Spurious rvalid while idle
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        tick();
        mem_rvalid_i = 1'b0;
        check("spur.done",  {31'd0, lsu_done_o}, 32'd0);
        check("spur.ready", {31'd0, lsu_ready_o}, 32'd1);
        tick();
        check("spur.done2", {31'd0, lsu_done_o}, 32'd0);
        check("spur.req",   {31'd0, mem_req_o}, 32'd0);

        // Reset in WAIT, then a late rvalid for the aborted transaction
        lsu_valid_i = 1'b1;
        lsu_we_i    = 1'b0;
        lsu_size_i  = 2'b10;
        lsu_addr_i  = 32'h0000_0020;
        lsu_rd_i    = 5'd8;
        tick();
        lsu_valid_i = 1'b0;
        check("abort.req", {31'd0, mem_req_o}, 32'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check("abort.wait", {31'd0, mem_req_o}, 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h7777_7777;
        check_reset_vals("abort");
        tick();
        mem_rvalid_i = 1'b0;
        check("abort.nodone",  {31'd0, lsu_done_o}, 32'd0);
        check("abort.ready",   {31'd0, lsu_ready_o}, 32'd1);
        check("abort.rdata",   lsu_rdata_o, 32'h0);

        xfer("lw", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 5'd7, 0, 0, 32'hDEAD_BEEF,
             32'h0000_0010, 4'b1111, 32'h0, 32'hDEAD_BEEF, 5'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
